// File: rtl/soundrive_i2s_tx_pkg.sv
// Shared definitions for the Soundrive/Covox audio output path.
//   SD_MIDSCALE    : offset-binary code for silence on a Soundrive DAC latch
//   I2S_SLOTS      : bit slots per stereo I2S frame (16 left + 16 right)
//   audio_sample_t : 16-bit two's-complement audio word
//   stereo_sample_t: packed {l, r} pair; l occupies the upper half
package soundrive_i2s_tx_pkg;

    localparam logic [7:0] SD_MIDSCALE = 8'h80;
    localparam int         I2S_SLOTS   = 32;

    typedef logic signed [15:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t l;
        audio_sample_t r;
    } stereo_sample_t;

endpackage

// File: rtl/soundrive_i2s_tx_if.sv
// Bundle between the Soundrive latch block, the I2S serialiser and the codec pins.
//   en_audio              : 0 mutes frames latched while low
//   ch_l0/ch_l1/ch_r0/ch_r1 : offset-binary DAC latch contents
//   i2s_bck/i2s_lrck/i2s_dat: Philips I2S towards the external DAC
//   sample_stb            : one-cycle pulse when a new frame is latched
// master = latch/board side, slave = serialiser.
interface soundrive_i2s_tx_if;

    logic       en_audio;
    logic [7:0] ch_l0;
    logic [7:0] ch_l1;
    logic [7:0] ch_r0;
    logic [7:0] ch_r1;
    logic       i2s_bck;
    logic       i2s_lrck;
    logic       i2s_dat;
    logic       sample_stb;

    modport master (
        output en_audio, ch_l0, ch_l1, ch_r0, ch_r1,
        input  i2s_bck, i2s_lrck, i2s_dat, sample_stb
    );

    modport slave (
        input  en_audio, ch_l0, ch_l1, ch_r0, ch_r1,
        output i2s_bck, i2s_lrck, i2s_dat, sample_stb
    );

endinterface

// File: rtl/soundrive_i2s_tx_mixer.sv
// soundrive_mixer: folds four offset-binary Soundrive channels into a registered
// stereo pair of 16-bit two's-complement words (one clk28 of latency).
// Ports:
//   clk28, rst      : clock and synchronous active-high reset
//   vld_p0          : input qualifier, carried alongside the data
//   ch_l0..ch_r1    : 8-bit offset-binary channel codes
//   vld_p1          : registered qualifier
//   mix_p1          : registered {l, r} words, each = {s0 + s1, 7'b0}
module soundrive_mixer
    import soundrive_i2s_tx_pkg::*;
(
    input  logic           clk28,
    input  logic           rst,
    input  logic           vld_p0,
    input  logic [7:0]     ch_l0,
    input  logic [7:0]     ch_l1,
    input  logic [7:0]     ch_r0,
    input  logic [7:0]     ch_r1,
    output logic           vld_p1,
    output stereo_sample_t mix_p1
);

    // Offset-binary to two's complement is just an MSB flip.
    function automatic logic signed [7:0] ob_to_s8(input logic [7:0] ch);
        return ch ^ SD_MIDSCALE;
    endfunction

    // Sum of two signed bytes spans -256..+254, so 9 bits hold it exactly.
    function automatic logic signed [8:0] add_s8(input logic signed [7:0] a,
                                                 input logic signed [7:0] b);
        return {a[7], a} + {b[7], b};
    endfunction

    // Left-justify into 16 bits; the 9-bit range always fits, so no clipping.
    function automatic audio_sample_t to_word(input logic signed [8:0] m);
        return {m, 7'b0};
    endfunction

    logic signed [8:0] sum_l_p0;
    logic signed [8:0] sum_r_p0;

    always_comb begin
        sum_l_p0 = add_s8(ob_to_s8(ch_l0), ob_to_s8(ch_l1));
        sum_r_p0 = add_s8(ob_to_s8(ch_r0), ob_to_s8(ch_r1));
    end

    // ---- stage p0 -> p1 ----
    always_ff @(posedge clk28) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            mix_p1 <= '0;
        end else begin
            vld_p1   <= vld_p0;
            mix_p1.l <= to_word(sum_l_p0);
            mix_p1.r <= to_word(sum_r_p0);
        end
    end

endmodule

// File: rtl/soundrive_i2s_tx.sv
// soundrive_i2s_tx: mixes the four Soundrive DAC latches to stereo and serialises
// them as 16-bit Philips I2S (left in slots 0..15, right in 16..31, MSB first).
// Ports:
//   clk28 : 28 MHz system clock (only clock)
//   rst   : synchronous active-high reset; aborts any frame in flight
//   bus   : slave side of soundrive_i2s_tx_if (channel inputs, en_audio,
//           i2s_bck/i2s_lrck/i2s_dat, sample_stb)
// BCK_HALF clk28 cycles per bck half-period (>= 2); frame = 64*BCK_HALF cycles.
module soundrive_i2s_tx
    import soundrive_i2s_tx_pkg::*;
#(
    parameter int BCK_HALF = 8
)
(
    input  logic                 clk28,
    input  logic                 rst,
    soundrive_i2s_tx_if.slave    bus
);

    localparam int                DIV_W    = $clog2(BCK_HALF);
    localparam int                SLOT_W   = $clog2(I2S_SLOTS);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCK_HALF - 1);

    logic           vld_p1;
    stereo_sample_t mix_p1;

    soundrive_mixer u_mixer (
        .clk28  (clk28),
        .rst    (rst),
        .vld_p0 (1'b1),
        .ch_l0  (bus.ch_l0),
        .ch_l1  (bus.ch_l1),
        .ch_r0  (bus.ch_r0),
        .ch_r1  (bus.ch_r1),
        .vld_p1 (vld_p1),
        .mix_p1 (mix_p1)
    );

    logic [DIV_W-1:0]  div;
    logic              bck;
    logic [SLOT_W-1:0] bit_cnt;
    logic [31:0]       shift_p2;
    logic              lrck_p2;
    logic              dat_p2;
    logic              stb_p2;

    logic              bck_tgl;
    logic              bck_fall;
    logic [SLOT_W-1:0] bit_cnt_n;
    logic [SLOT_W-1:0] lrck_slot;
    logic              frame_start;
    logic [31:0]       shift_n;

    always_comb begin
        bck_tgl     = (div == DIV_LAST);
        bck_fall    = bck_tgl && bck;
        bit_cnt_n   = bit_cnt + SLOT_W'(1);
        // lrck looks one slot ahead so it leads each word's MSB by one bck.
        lrck_slot   = bit_cnt_n + SLOT_W'(1);
        frame_start = (bit_cnt_n == '0);
        shift_n     = shift_p2 << 1;
        if (frame_start) begin
            shift_n = (bus.en_audio && vld_p1) ? mix_p1 : 32'h0;
        end
    end

    // ---- stage p1 -> p2 ----
    always_ff @(posedge clk28) begin
        if (rst) begin
            div      <= '0;
            bck      <= 1'b0;
            bit_cnt  <= '1;
            shift_p2 <= '0;
            lrck_p2  <= 1'b0;
            dat_p2   <= 1'b0;
            stb_p2   <= 1'b0;
        end else begin
            stb_p2 <= 1'b0;
            if (bck_tgl) begin
                div <= '0;
                bck <= ~bck;
            end else begin
                div <= div + DIV_W'(1);
            end
            // Data and word select advance only on the falling bck edge,
            // giving the DAC a full half-period of setup before each rise.
            if (bck_fall) begin
                bit_cnt  <= bit_cnt_n;
                shift_p2 <= shift_n;
                dat_p2   <= shift_n[31];
                lrck_p2  <= lrck_slot[SLOT_W-1];
                stb_p2   <= frame_start;
            end
        end
    end

    assign bus.i2s_bck    = bck;
    assign bus.i2s_lrck   = lrck_p2;
    assign bus.i2s_dat    = dat_p2;
    assign bus.sample_stb = stb_p2;

endmodule
